// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC module IDs, opcodes, beat lengths and arbiter state encoding
package noc_pkg;
   localparam logic [1:0] MEM  = 2'd0;
   localparam logic [1:0] SHA  = 2'd1;
   localparam logic [1:0] AES  = 2'd2;
   localparam logic [1:0] CTRL = 2'd3;

   localparam logic [3:0] RD_KEY  = 4'h1;
   localparam logic [3:0] RD_TEXT = 4'h2;
   localparam logic [3:0] WR_RES  = 4'h3;
   localparam logic [3:0] HASH_OP = 4'h4;

   localparam int HDR_BEATS = 4;
   localparam int AES_BEATS = 16;
   localparam int SHA_BEATS = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_TURN = 2'd2;
endpackage

// File: rtl/noc_bus_arbiter_rr_picker.sv
// rtl/noc_bus_arbiter_rr_picker.sv - combinational rotating-priority picker
module rr_picker
   import noc_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] req,
   input  logic [1:0]       rr_ptr,
   output logic [1:0]       winner,
   output logic             valid
);

   logic [1:0] idx;

   // First set bit at or above rr_ptr, wrapping past the top index.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = 2'((int'(rr_ptr) + i) % N_REQ);
         if (!valid && req[idx]) begin
            valid  = 1'b1;
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/noc_bus_arbiter.sv
// rtl/noc_bus_arbiter.sv - round-robin owner arbiter for the shared 8-bit NoC bus
module noc_bus_arbiter
   import noc_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int MAX_BEATS = 36,
   parameter int TIMEOUT   = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] last,
   input  logic             bus_valid,
   input  logic             bus_ready,
   output logic [N_REQ-1:0] grant,
   output logic [1:0]       owner_id,
   output logic             bus_busy,
   output logic [5:0]       beat_cnt,
   output logic             timeout_err,
   output logic [1:0]       err_id
);

   localparam logic [5:0] MAX_B   = 6'(MAX_BEATS);
   localparam logic [7:0] TO_LIM  = 8'(TIMEOUT);
   localparam logic [1:0] LAST_ID = 2'(N_REQ - 1);
   localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   logic [1:0] state;
   logic [1:0] rr_ptr;
   logic [7:0] stall;
   logic [1:0] pick_id;
   logic       pick_valid;

   logic       beat;
   logic       rel_a, rel_b, rel_c, rel_d, rel;
   logic [5:0] beat_nxt;
   logic [7:0] stall_nxt;

   rr_picker #(.N_REQ(N_REQ)) u_picker (
      .req    (req),
      .rr_ptr (rr_ptr),
      .winner (pick_id),
      .valid  (pick_valid)
   );

   assign beat      = bus_valid && bus_ready;
   assign beat_nxt  = (beat && beat_cnt < MAX_B) ? beat_cnt + 6'd1 : beat_cnt;
   assign stall_nxt = beat ? 8'd0 : ((stall == 8'hff) ? stall : stall + 8'd1);

   // The stall test uses the count already accumulated, so a beat with last
   // landing on the timeout cycle still counts as a normal release.
   assign rel_a = beat && last[owner_id];
   assign rel_b = !req[owner_id];
   assign rel_c = beat && (beat_nxt == MAX_B);
   assign rel_d = (stall >= TO_LIM);
   assign rel   = rel_a || rel_b || rel_c || rel_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         rr_ptr      <= '0;
         stall       <= '0;
         grant       <= '0;
         owner_id    <= '0;
         bus_busy    <= 1'b0;
         beat_cnt    <= '0;
         timeout_err <= 1'b0;
         err_id      <= '0;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            ST_BUSY: begin
               beat_cnt <= beat_nxt;
               stall    <= stall_nxt;
               if (rel) begin
                  grant    <= '0;
                  owner_id <= '0;
                  bus_busy <= 1'b0;
                  rr_ptr   <= (owner_id == LAST_ID) ? 2'd0 : owner_id + 2'd1;
                  state    <= ST_TURN;
                  if (rel_d && !rel_a && !rel_b && !rel_c) begin
                     timeout_err <= 1'b1;
                     err_id      <= owner_id;
                  end
               end
            end
            default: begin
               if (pick_valid) begin
                  grant    <= ONE << pick_id;
                  owner_id <= pick_id;
                  bus_busy <= 1'b1;
                  beat_cnt <= '0;
                  stall    <= '0;
                  state    <= ST_BUSY;
               end else begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_noc_bus_arbiter.sv
// tb/tb_noc_bus_arbiter.sv - randomized self-checking bench for noc_bus_arbiter
module tb_noc_bus_arbiter;
   localparam int N = 4;
   localparam int MAXB = 36;
   localparam int TMO = 255;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req = '0;
   logic [N-1:0] last = '0;
   logic         bus_valid = 1'b0;
   logic         bus_ready = 1'b0;
   logic [N-1:0] grant;
   logic [1:0]   owner_id;
   logic         bus_busy;
   logic [5:0]   beat_cnt;
   logic         timeout_err;
   logic [1:0]   err_id;

   int n_vec = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Reference: who owns the bus (-1 none), beats and stall cycles so far.
   int m_own = -1, m_ptr = 0, m_beats = 0, m_stall = 0, m_errid = 0;
   bit m_terr = 1'b0;

   noc_bus_arbiter #(.N_REQ(N), .MAX_BEATS(MAXB), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .req(req), .last(last),
      .bus_valid(bus_valid), .bus_ready(bus_ready),
      .grant(grant), .owner_id(owner_id), .bus_busy(bus_busy),
      .beat_cnt(beat_cnt), .timeout_err(timeout_err), .err_id(err_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_own = -1; m_ptr = 0; m_beats = 0; m_stall = 0; m_errid = 0; m_terr = 0;
      end else begin
         m_terr = 0;
         if (m_own >= 0) begin
            bit hs, a, b, c, d;
            hs = bus_valid && bus_ready;
            a  = hs && last[m_own];
            b  = !req[m_own];
            d  = (m_stall >= TMO);
            if (hs && m_beats < MAXB) m_beats++;
            c  = hs && (m_beats == MAXB);
            if (hs) m_stall = 0;
            else if (m_stall < 255) m_stall++;
            if (a || b || c || d) begin
               if (d && !a && !b && !c) begin
                  m_terr = 1; m_errid = m_own;
               end
               m_ptr = (m_own + 1) % N;
               m_own = -1;
            end
         end else begin
            for (int k = 0; k < N; k++) begin
               if (m_own < 0 && req[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
            end
            if (m_own >= 0) begin
               m_beats = 0; m_stall = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("grant", int'(grant), (m_own >= 0) ? (1 << m_own) : 0);
         check("owner_id", int'(owner_id), (m_own >= 0) ? m_own : 0);
         check("bus_busy", int'(bus_busy), (m_own >= 0) ? 1 : 0);
         check("beat_cnt", int'(beat_cnt), m_beats);
         check("timeout_err", int'(timeout_err), int'(m_terr));
         check("err_id", int'(err_id), m_errid);
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1; req = '0; last = '0; bus_valid = 0; bus_ready = 0;
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      int owners[$];
      int cnt, gap;
      logic [N-1:0] prev_g;

      @(negedge clk);
      chk_en = 1;
      check("rst_grant", int'(grant), 0);
      check("rst_beat", int'(beat_cnt), 0);
      check("rst_terr", int'(timeout_err), 0);
      rst = 0;

      // Single SHA request, 36 beats with last on the final one.
      repeat (3) @(negedge clk);
      req = 4'b0010;
      @(negedge clk);
      check("single_grant", int'(grant), 2);
      check("single_owner", int'(owner_id), 1);
      bus_valid = 1; bus_ready = 1;
      for (int k = 1; k <= 36; k++) begin
         last = (k == 36) ? 4'b0010 : 4'b0000;
         if (k == 36) req = 4'b0000;
         @(negedge clk);
      end
      last = '0; bus_valid = 0; bus_ready = 0;
      check("single_turn_grant", int'(grant), 0);
      check("single_beats", int'(beat_cnt), 36);
      check("single_terr", int'(timeout_err), 0);

      // Round-robin with 4-beat packets.
      do_reset();
      req = 4'b1111; bus_valid = 1; bus_ready = 1;
      prev_g = '0; gap = 0;
      for (int cyc = 0; cyc < 60 && owners.size() < 5; cyc++) begin
         last = (m_own >= 0 && m_beats == 3) ? 4'b1111 : 4'b0000;
         @(negedge clk);
         if (grant != 0 && prev_g == 0) begin
            if (owners.size() > 0) check("rr_gap", gap, 1);
            owners.push_back(int'(owner_id));
            gap = 0;
         end
         if (grant == 0) gap++;
         prev_g = grant;
      end
      check("rr_count", owners.size(), 5);
      for (int k = 0; k < owners.size(); k++) check("rr_order", owners[k], k % 4);
      req = '0; last = '0; bus_valid = 0; bus_ready = 0;

      // AES drops its request after 3 beats; CTRL is next.
      do_reset();
      req = 4'b0100;
      @(negedge clk);
      check("drop_grant", int'(grant), 4);
      bus_valid = 1; bus_ready = 1;
      repeat (3) @(negedge clk);
      bus_valid = 0; req = 4'b1000;
      @(negedge clk);
      check("drop_turn", int'(grant), 0);
      check("drop_beats", int'(beat_cnt), 3);
      @(negedge clk);
      check("drop_next", int'(grant), 8);
      req = '0;

      // Stall timeout on MEM.
      do_reset();
      req = 4'b0001;
      cnt = 0;
      while (timeout_err !== 1'b1 && cnt < 400) begin
         @(negedge clk);
         cnt++;
      end
      check("tmo_seen", int'(timeout_err === 1'b1), 1);
      check("tmo_errid", int'(err_id), 0);
      check("tmo_grant", int'(grant), 0);
      @(negedge clk);
      check("tmo_pulse", int'(timeout_err), 0);
      req = '0;

      // last on a beat in the timeout cycle: normal release.
      do_reset();
      req = 4'b0001;
      cnt = 0;
      while (!(m_own == 0 && m_stall == 255) && cnt < 400) begin
         @(negedge clk);
         cnt++;
      end
      check("tmo2_reached", int'(m_stall), 255);
      bus_valid = 1; bus_ready = 1; last = 4'b0001;
      @(negedge clk);
      check("tmo2_grant", int'(grant), 0);
      check("tmo2_terr", int'(timeout_err), 0);
      req = '0; last = '0; bus_valid = 0; bus_ready = 0;

      // Beat limit without last.
      do_reset();
      req = 4'b0100; bus_valid = 1; bus_ready = 1;
      @(negedge clk);
      cnt = 0;
      while (grant != 0 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      check("limit_cycles", cnt, 36);
      check("limit_beats", int'(beat_cnt), 36);
      check("limit_terr", int'(timeout_err), 0);
      req = '0; bus_valid = 0; bus_ready = 0;

      // Reset during beat 10 of a CTRL grant.
      do_reset();
      req = 4'b1000; bus_valid = 1; bus_ready = 1;
      @(negedge clk);
      repeat (9) @(negedge clk);
      rst = 1; req = 4'b1001;
      @(negedge clk);
      check("rstmid_grant", int'(grant), 0);
      check("rstmid_beats", int'(beat_cnt), 0);
      rst = 0;
      @(negedge clk);
      check("rstmid_mem_first", int'(grant), 1);
      req = '0; bus_valid = 0; bus_ready = 0;

      // Randomized traffic against the reference.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(15) == 0) req[b] = ~req[b];
         for (int b = 0; b < N; b++) last[b] = ($urandom_range(9) == 0);
         bus_valid = ($urandom_range(3) != 0);
         bus_ready = ((cyc % 700) < 350) ? 1'b0 : ($urandom_range(3) != 0);
         rst = ($urandom_range(599) == 0);
         @(negedge clk);
      end
      rst = 0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
